// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and Gray-code helpers for the Gray sequence generator
package gray_pkg;

   // Widest code the helper functions handle; callers zero-extend and truncate.
   localparam int GRAY_MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_flip_enc.sv
// rtl/gray_flip_enc.sv - one-hot to bit-index encoder for the flipped Gray bit
module gray_flip_enc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         onehot,
   output logic [$clog2(WIDTH)-1:0] idx
);

   localparam int IW = $clog2(WIDTH);

   // Priority scan; with a true one-hot input the highest set bit is the only set bit.
   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) begin
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/gray_seq_gen.sv
// rtl/gray_seq_gen.sv - up/down Gray-code sequence generator with valid/ready output
module gray_seq_gen
   import gray_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     dir,
   input  logic [WIDTH-1:0]         start_val,
   input  logic [WIDTH-1:0]         len,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_gray,
   output logic [WIDTH-1:0]         out_bin,
   output logic [$clog2(WIDTH)-1:0] flip_idx,
   output logic                     busy,
   output logic                     done
);

   localparam int IW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             valid_d;
   logic [WIDTH-1:0] gray_d;
   logic [IW-1:0]    flip_d;
   logic             busy_d;
   logic             done_d;

   logic [WIDTH-1:0] step_bin;
   logic [WIDTH-1:0] step_gray;
   logic [IW-1:0]    step_flip;

   // Next code in the latched direction; modulo arithmetic gives the wrap for free.
   assign step_bin  = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
   assign step_gray = WIDTH'(bin2gray(GRAY_MAX_W'(step_bin)));

   gray_flip_enc #(
      .WIDTH (WIDTH)
   ) u_flip_enc (
      .onehot (out_gray ^ step_gray),
      .idx    (step_flip)
   );

   // Next-state and next-output decode; every output is registered from these values.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      valid_d = out_valid;
      gray_d  = out_gray;
      flip_d  = flip_idx;
      busy_d  = busy;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            if (start && !abort) begin
               state_d = RUN;
               bin_d   = start_val;
               rem_d   = len;
               dir_d   = dir;
               valid_d = 1'b1;
               gray_d  = WIDTH'(bin2gray(GRAY_MAX_W'(start_val)));
               flip_d  = '0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (out_valid && out_ready) begin
               if (rem_q == '0) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bin_d  = step_bin;
                  rem_d  = rem_q - WIDTH'(1);
                  gray_d = step_gray;
                  flip_d = step_flip;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter and output registers; out_bin is the live binary counter itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q     <= '0;
         rem_q     <= '0;
         dir_q     <= 1'b0;
         out_valid <= 1'b0;
         out_gray  <= '0;
         flip_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         rem_q     <= rem_d;
         dir_q     <= dir_d;
         out_valid <= valid_d;
         out_gray  <= gray_d;
         flip_idx  <= flip_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   assign out_bin = bin_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// tb/tb_gray_seq_gen.sv - directed self-checking bench for gray_seq_gen
module tb_gray_seq_gen;
   import gray_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] start_val = 8'h00;
   logic [7:0] len = 8'h00;
   logic       out_ready = 1'b1;
   logic       out_valid;
   logic [7:0] out_gray;
   logic [7:0] out_bin;
   logic [2:0] flip_idx;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   gray_seq_gen #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .dir       (dir),
      .start_val (start_val),
      .len       (len),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_gray  (out_gray),
      .out_bin   (out_bin),
      .flip_idx  (flip_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_code(input string tag, input logic [7:0] bin, input logic [7:0] gray,
                           input logic [2:0] flip);
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " bin"}, 32'(out_bin), 32'(bin));
      chk({tag, " gray"}, 32'(out_gray), 32'(gray));
      chk({tag, " flip"}, 32'(flip_idx), 32'(flip));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " valid"}, 32'(out_valid), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
   endtask

   task automatic go(input logic [7:0] sv, input logic [7:0] l, input logic d);
      start_val = sv;
      len = l;
      dir = d;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, " done pulse"}, 32'(done), 32'd1);
      chk({tag, " done valid"}, 32'(out_valid), 32'd0);
      chk({tag, " done busy"}, 32'(busy), 32'd1);
      tick();
      chk_idle({tag, " after done"});
   endtask

   initial begin
      #1;
      chk("reset gray", 32'(out_gray), 32'h00);
      chk_idle("reset");
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk_idle("idle after release");

      // Reset in the middle of a sequence clears outputs without waiting for a clock.
      go(8'h10, 8'h05, 1'b0);
      chk_code("pre-rst c0", 8'h10, 8'h18, 3'd0);
      tick();
      chk_code("pre-rst c1", 8'h11, 8'h19, 3'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst gray", 32'(out_gray), 32'h00);
      chk_idle("midrst");
      #1;
      rst = 1'b0;
      tick();
      tick();
      chk_idle("post-rst idle");

      // Count up 0..3 with ready held high.
      out_ready = 1'b1;
      go(8'h00, 8'h03, 1'b0);
      chk_code("up c0", 8'h00, 8'h00, 3'd0);
      tick();
      chk_code("up c1", 8'h01, 8'h01, 3'd0);
      tick();
      chk_code("up c2", 8'h02, 8'h03, 3'd1);
      tick();
      chk_code("up c3", 8'h03, 8'h02, 3'd0);
      tick();
      chk_done("up");

      // Upward wrap through FF -> 00.
      go(8'hFE, 8'h02, 1'b0);
      chk_code("wrapup c0", 8'hFE, 8'h81, 3'd0);
      tick();
      chk_code("wrapup c1", 8'hFF, 8'h80, 3'd0);
      tick();
      chk_code("wrapup c2", 8'h00, 8'h00, 3'd7);
      tick();
      chk_done("wrapup");

      // Downward wrap through 00 -> FF.
      go(8'h01, 8'h02, 1'b1);
      chk_code("down c0", 8'h01, 8'h01, 3'd0);
      tick();
      chk_code("down c1", 8'h00, 8'h00, 3'd0);
      tick();
      chk_code("down c2", 8'hFF, 8'h80, 3'd7);
      tick();
      chk_done("down");

      // Backpressure on the second code holds it stable.
      go(8'h00, 8'h03, 1'b0);
      chk_code("bp c0", 8'h00, 8'h00, 3'd0);
      tick();
      chk_code("bp c1", 8'h01, 8'h01, 3'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_code("bp hold", 8'h01, 8'h01, 3'd0);
      end
      out_ready = 1'b1;
      tick();
      chk_code("bp c2", 8'h02, 8'h03, 3'd1);
      tick();
      chk_code("bp c3", 8'h03, 8'h02, 3'd0);
      tick();
      chk_done("bp");

      // Start while busy is ignored, abort ends the run without done.
      go(8'h00, 8'h05, 1'b0);
      chk_code("ab c0", 8'h00, 8'h00, 3'd0);
      tick();
      chk_code("ab c1", 8'h01, 8'h01, 3'd0);
      start_val = 8'h40;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_code("ab c2", 8'h02, 8'(bin2gray(32'h2)), 3'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("abort");
      tick();
      chk_idle("abort+1");

      // start and abort together in IDLE: stays idle.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk_idle("start+abort");
      tick();
      chk_idle("start+abort+1");

      // len=0 emits one code; start held through DONE is not accepted there.
      start_val = 8'h55;
      len = 8'h00;
      dir = 1'b0;
      start = 1'b1;
      tick();
      chk_code("len0 c0", 8'h55, 8'h7F, 3'd0);
      tick();
      chk("len0 done", 32'(done), 32'd1);
      tick();
      start = 1'b0;
      chk_idle("len0 start in done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
